// File: rtl/expr_eval.sv
// Streaming evaluator for digit(op digit)* frames terminated by '='.
// '*' binds tighter than '+'; one result pulse per frame, modulo 2^WIDTH.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             expr_ok,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_err,
  output logic             result_ovf
);

  typedef enum logic [1:0] {
    EXP_NUM = 2'd0,
    EXP_OP  = 2'd1,
    ERR     = 2'd2
  } st_t;

  st_t              st;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] prod;
  logic             ovf_acc;

  logic             is_dig;
  logic             is_add;
  logic             is_mul;
  logic             is_eq;
  logic [WIDTH+3:0] pm;
  logic [WIDTH:0]   sp;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign is_dig = (in >= 8'h30) && (in <= 8'h39);
  assign is_add = (in == 8'h2b);
  assign is_mul = (in == 8'h2a);
  assign is_eq  = (in == 8'h3d);

  // Low nibble of an ASCII digit is its value.
  assign pm = {4'b0, prod} * {{WIDTH{1'b0}}, in[3:0]};
  assign sp = {1'b0, sum} + {1'b0, prod};

  always_ff @(posedge clk) begin
    if (clr) begin
      st           <= EXP_NUM;
      sum          <= '0;
      prod         <= ONE;
      ovf_acc      <= 1'b0;
      expr_ok      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      result_ovf   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (in_valid) begin
        expr_ok <= 1'b0;
        unique case (st)
          EXP_NUM: begin
            unique case (1'b1)
              is_dig: begin
                prod    <= pm[WIDTH-1:0];
                ovf_acc <= ovf_acc | (|pm[WIDTH+3:WIDTH]);
                st      <= EXP_OP;
                expr_ok <= 1'b1;
              end
              is_eq: begin
                result       <= '0;
                result_valid <= 1'b1;
                result_err   <= 1'b1;
                result_ovf   <= 1'b0;
                sum          <= '0;
                prod         <= ONE;
                ovf_acc      <= 1'b0;
                st           <= EXP_NUM;
              end
              default: st <= ERR;
            endcase
          end
          EXP_OP: begin
            unique case (1'b1)
              is_add: begin
                sum     <= sp[WIDTH-1:0];
                ovf_acc <= ovf_acc | sp[WIDTH];
                prod    <= ONE;
                st      <= EXP_NUM;
              end
              is_mul: st <= EXP_NUM;
              is_eq: begin
                result       <= sp[WIDTH-1:0];
                result_valid <= 1'b1;
                result_err   <= 1'b0;
                result_ovf   <= ovf_acc | sp[WIDTH];
                sum          <= '0;
                prod         <= ONE;
                ovf_acc      <= 1'b0;
                st           <= EXP_NUM;
              end
              default: st <= ERR;
            endcase
          end
          ERR: begin
            if (is_eq) begin
              result       <= '0;
              result_valid <= 1'b1;
              result_err   <= 1'b1;
              result_ovf   <= 1'b0;
              sum          <= '0;
              prod         <= ONE;
              ovf_acc      <= 1'b0;
              st           <= EXP_NUM;
            end
          end
          default: st <= ERR;
        endcase
      end
    end
  end

endmodule
